// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and helpers used by the operand-select pipeline.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  // Operand source indices as seen by the forwarding/hazard unit
  localparam int unsigned OPSRC_RF    = 0;
  localparam int unsigned OPSRC_EXMEM = 1;
  localparam int unsigned OPSRC_MEMWB = 2;
  localparam int unsigned OPSRC_IMM   = 3;

  // Index width for n items, never below one bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/mips_operand_sel_pipe_if.sv
// Producer/consumer bus of the operand-select pipeline.
// MIPS_OPSEL_ERRCNT_EN adds the select-error counter and its clear.
interface mips_operand_sel_pipe_if
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned NSRC  = 4
);

  localparam int unsigned SELW = clog2_min1(NSRC);

  logic [NSRC*WIDTH-1:0] in_data;
  logic [SELW-1:0]       in_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sel_err;
`ifdef MIPS_OPSEL_ERRCNT_EN
  logic [7:0]            sel_err_cnt;
  logic                  sel_err_clr;

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready, sel_err_clr,
    input  in_ready, out_data, out_valid, sel_err, sel_err_cnt
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready, sel_err_clr,
    output in_ready, out_data, out_valid, sel_err, sel_err_cnt
  );
`else
  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );
`endif

endinterface

// File: rtl/mips_pipe_slot.sv
// One elastic register slot: holds a word plus its select-error tag, loads when
// empty or when downstream takes the current content, emptied by flush.
module mips_pipe_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_err,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  logic load_c;

  assign load_c = !out_valid || out_ready;

  // Flush drops the valid only; the data and tag registers keep their contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_c) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_err  <= in_err;
      end
    end
  end

endmodule

// File: rtl/mips_operand_sel_pipe.sv
// ALU operand source select (RF / EX-MEM / MEM-WB / IMM) feeding a stallable,
// flushable elastic pipeline. Optional MIPS_OPSEL_ERRCNT_EN: bad-select counter.
module mips_operand_sel_pipe
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_W,
  parameter int unsigned NSRC   = 4,
  parameter int unsigned STAGES = 1
) (
  input logic                    clk,
  input logic                    reset,
  mips_operand_sel_pipe_if.slave bus
);

  localparam int unsigned SELW  = clog2_min1(NSRC);
  localparam int unsigned SELW1 = SELW + 1;

  logic [WIDTH-1:0]             sel_word;
  logic                         sel_bad;
  logic                         accept;
  logic [STAGES-1:0]            slot_valid;
  logic [STAGES-1:0][WIDTH-1:0] slot_data;
  logic [STAGES-1:0]            slot_err;
  logic [STAGES:0]              feed_valid;
  logic [STAGES:0][WIDTH-1:0]   feed_data;
  logic [STAGES:0]              feed_err;
  logic [STAGES:0]              down_ready;
  logic                         sel_err_q;
  logic                         unused_tail_err;

  // Out-of-range select falls back to source 0 (only reachable for non-power-of-2 NSRC)
  assign sel_bad = {1'b0, bus.in_sel} >= SELW1'(NSRC);

  always_comb begin
    sel_word = bus.in_data[WIDTH-1:0];
    for (int unsigned k = 1; k < NSRC; k++) begin
      if (bus.in_sel == SELW'(k)) sel_word = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  // Slot i can take a word when it or any slot after it is empty, or the consumer drains
  always_comb begin
    logic room;
    room               = bus.out_ready;
    down_ready         = '0;
    down_ready[STAGES] = room;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      room          = room || !slot_valid[i];
      down_ready[i] = room;
    end
  end

  assign bus.in_ready = !bus.flush && down_ready[0];
  assign accept       = bus.in_valid && bus.in_ready;

  assign feed_valid = {slot_valid, accept};
  assign feed_data  = {slot_data, sel_word};
  assign feed_err   = {slot_err, sel_bad};

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    mips_pipe_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.flush),
      .in_valid  (feed_valid[i]),
      .in_data   (feed_data[i]),
      .in_err    (feed_err[i]),
      .out_ready (down_ready[i+1]),
      .out_valid (slot_valid[i]),
      .out_data  (slot_data[i]),
      .out_err   (slot_err[i])
    );
  end

  assign bus.out_valid = feed_valid[STAGES];
  assign bus.out_data  = feed_data[STAGES];
  assign unused_tail_err = feed_err[STAGES];

  // One-cycle pulse per accepted bad select; flush blocks acceptance so it also clears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_err_q <= 1'b0;
    else       sel_err_q <= accept && sel_bad;
  end

  assign bus.sel_err = sel_err_q;

`ifdef MIPS_OPSEL_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of accepted bad selects; clear wins over a coincident increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else if (bus.sel_err_clr) begin
      err_cnt_q <= 8'd0;
    end else if (accept && sel_bad && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.sel_err_cnt = err_cnt_q;
`endif

  a_hold_under_stall: assert property (@(posedge clk) disable iff (reset)
    (bus.out_valid && !bus.out_ready) |=> $stable(bus.out_data));

  a_err_from_accept: assert property (@(posedge clk) disable iff (reset)
    sel_err_q |-> $past(accept && sel_bad));

endmodule

// File: tb/tb_mips_operand_sel_pipe.sv
// Scoreboard bench for mips_operand_sel_pipe across three configurations
// (NSRC=4/STAGES=1, NSRC=4/STAGES=2, NSRC=3/STAGES=3).
module tb_mips_operand_sel_pipe;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mips_operand_sel_pipe_if #(.WIDTH(32), .NSRC(4)) ia ();
  mips_operand_sel_pipe_if #(.WIDTH(32), .NSRC(4)) ib ();
  mips_operand_sel_pipe_if #(.WIDTH(32), .NSRC(3)) ic ();

  mips_operand_sel_pipe #(.WIDTH(32), .NSRC(4), .STAGES(1)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
  mips_operand_sel_pipe #(.WIDTH(32), .NSRC(4), .STAGES(2)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));
  mips_operand_sel_pipe #(.WIDTH(32), .NSRC(3), .STAGES(3)) dut_c (.clk(clk), .reset(reset), .bus(ic.slave));

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  logic [31:0] exp_a [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0] exp_c [5] = '{32'h10000000, 32'h10000011, 32'h10000022, 32'h10000030, 32'h10000041};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every beat handed to the consumer must match the oldest expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (ia.out_valid && ia.out_ready) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_beat: actual=%h required=none", ia.out_data);
        end else chk("a_out_data", ia.out_data, qa.pop_front());
      end
      if (ib.out_valid && ib.out_ready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_beat: actual=%h required=none", ib.out_data);
        end else chk("b_out_data", ib.out_data, qb.pop_front());
      end
      if (ic.out_valid && ic.out_ready) begin
        if (qc.size() == 0) begin
          checks++; errors++;
          $display("FAIL c_unexpected_beat: actual=%h required=none", ic.out_data);
        end else chk("c_out_data", ic.out_data, qc.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int nacc;

    reset = 1'b1;
    ia.in_data = '0; ia.in_sel = '0; ia.in_valid = 1'b0; ia.flush = 1'b0; ia.out_ready = 1'b1;
    ib.in_data = '0; ib.in_sel = '0; ib.in_valid = 1'b0; ib.flush = 1'b0; ib.out_ready = 1'b1;
    ic.in_data = '0; ic.in_sel = '0; ic.in_valid = 1'b0; ic.flush = 1'b0; ic.out_ready = 1'b1;
`ifdef MIPS_OPSEL_ERRCNT_EN
    ia.sel_err_clr = 1'b0; ib.sel_err_clr = 1'b0; ic.sel_err_clr = 1'b0;
`endif

    // Reset state
    #12;
    chk("a_rst_valid", ia.out_valid, 0); chk("a_rst_data", ia.out_data, 0); chk("a_rst_err", ia.sel_err, 0);
    chk("b_rst_valid", ib.out_valid, 0); chk("b_rst_data", ib.out_data, 0); chk("b_rst_err", ib.sel_err, 0);
    chk("c_rst_valid", ic.out_valid, 0); chk("c_rst_data", ic.out_data, 0); chk("c_rst_err", ic.sel_err, 0);
`ifdef MIPS_OPSEL_ERRCNT_EN
    chk("c_rst_cnt", ic.sel_err_cnt, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("a_ready_after_rst", ia.in_ready, 1);
    chk("b_ready_after_rst", ib.in_ready, 1);
    chk("c_ready_after_rst", ic.in_ready, 1);

    // Select sweep, STAGES=1: back-to-back beats, no bubbles
    tick();
    ia.in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    for (int s = 0; s < 4; s++) begin
      ia.in_sel   = 2'(s);
      ia.in_valid = 1'b1;
      @(negedge clk);
      chk("a_in_ready", ia.in_ready, 1);
      if (ia.in_ready) qa.push_back(exp_a[s]);
      if (s > 0) chk("a_no_bubble", ia.out_valid, 1);
      tick();
    end
    ia.in_valid = 1'b0;
    @(negedge clk);
    chk("a_last_valid", ia.out_valid, 1);
    tick();
    @(negedge clk);
    chk("a_drained", ia.out_valid, 0);

    // Reset with two beats in flight, STAGES=2
    tick();
    ib.in_data   = {32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001, 32'hBBBB0000};
    ib.out_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      ib.in_sel   = 2'(s + 1);
      ib.in_valid = 1'b1;
      @(negedge clk);
      if (ib.in_ready) qb.push_back(32'hBBBB0001 + 32'(s));
      tick();
    end
    ib.in_valid = 1'b0;
    chk("b_inflight_valid", ib.out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("b_async_rst_valid", ib.out_valid, 0);
    chk("b_async_rst_data", ib.out_data, 0);
    qa.delete(); qb.delete(); qc.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("b_ready_after_midrst", ib.in_ready, 1);

    // Flush of a full STAGES=2 pipe with a beat offered
    tick();
    ib.out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      ib.in_sel   = 2'(s);
      ib.in_valid = 1'b1;
      @(negedge clk);
      chk("b_fill_ready", ib.in_ready, 1);
      if (ib.in_ready) qb.push_back(32'hBBBB0000 + 32'(s));
      tick();
    end
    ib.in_sel = 2'd3;
    ib.flush  = 1'b1;
    @(negedge clk);
    chk("b_flush_ready", ib.in_ready, 0);
    chk("b_full_before_flush", ib.out_valid, 1);
    tick();
    ib.flush    = 1'b0;
    ib.in_valid = 1'b0;
    qb.delete();
    @(negedge clk);
    chk("b_flush_empty", ib.out_valid, 0);
    chk("b_ready_after_flush", ib.in_ready, 1);
    tick();
    ib.out_ready = 1'b1;
    ib.in_sel    = 2'd2;
    ib.in_valid  = 1'b1;
    @(negedge clk);
    chk("b_post_flush_ready", ib.in_ready, 1);
    if (ib.in_ready) qb.push_back(32'hBBBB0002);
    tick();
    ib.in_valid = 1'b0;
    @(negedge clk);
    chk("b_latency_cycle1", ib.out_valid, 0);
    tick();
    @(negedge clk);
    chk("b_latency_cycle2", ib.out_valid, 1);
    tick();
    @(negedge clk);
    chk("b_after_drain", ib.out_valid, 0);

    // Backpressure, STAGES=3: five beats against a stalled consumer
    tick();
    ic.out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
      ic.in_data  = {32'h10000002 + 32'(idx * 16), 32'h10000001 + 32'(idx * 16), 32'h10000000 + 32'(idx * 16)};
      ic.in_sel   = 2'(idx % 3);
      ic.in_valid = 1'b1;
      if (cyc == 5) ic.out_ready = 1'b1;
      @(negedge clk);
      if (cyc < 5) chk("c_bp_in_ready", ic.in_ready, (cyc < 3) ? 1 : 0);
      if (cyc == 3 || cyc == 4) begin
        chk("c_bp_hold_valid", ic.out_valid, 1);
        chk("c_bp_hold_data", ic.out_data, 32'h10000000);
      end
      if (ic.in_ready) begin
        qc.push_back(exp_c[idx]);
        idx++;
      end
      tick();
    end
    ic.in_valid = 1'b0;
    chk("c_bp_all_accepted", 32'(idx), 5);
    for (int w = 0; w < 20 && qc.size() != 0; w++) tick();
    chk("c_bp_drained", 32'(qc.size()), 0);

    // Out-of-range select, NSRC=3
    tick();
    ic.out_ready = 1'b1;
    ic.in_data   = {32'h33333333, 32'h22222222, 32'hDEADBEEF};
    ic.in_sel    = 2'd1;
    ic.in_valid  = 1'b1;
    @(negedge clk);
    chk("c_err_idle", ic.sel_err, 0);
    if (ic.in_ready) qc.push_back(32'h22222222);
    tick();
    ic.in_sel = 2'd3;
    @(negedge clk);
    chk("c_err_good_sel", ic.sel_err, 0);
    if (ic.in_ready) qc.push_back(32'hDEADBEEF);
    tick();
    ic.in_valid = 1'b0;
    @(negedge clk);
    chk("c_err_pulse", ic.sel_err, 1);
    tick();
    @(negedge clk);
    chk("c_err_pulse_end", ic.sel_err, 0);
    for (int w = 0; w < 20 && qc.size() != 0; w++) tick();
    chk("c_oor_drained", 32'(qc.size()), 0);

`ifdef MIPS_OPSEL_ERRCNT_EN
    // Counter saturation and clear-over-increment
    tick();
    ic.in_sel   = 2'd3;
    ic.in_valid = 1'b1;
    nacc = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (ic.in_ready) begin
        qc.push_back(32'hDEADBEEF);
        nacc++;
      end
      tick();
    end
    ic.in_valid = 1'b0;
    @(negedge clk);
    chk("c_cnt_accepts", 32'(nacc), 300);
    chk("c_cnt_saturated", ic.sel_err_cnt, 255);
    tick();
    ic.in_valid    = 1'b1;
    ic.sel_err_clr = 1'b1;
    @(negedge clk);
    if (ic.in_ready) qc.push_back(32'hDEADBEEF);
    tick();
    ic.in_valid    = 1'b0;
    ic.sel_err_clr = 1'b0;
    @(negedge clk);
    chk("c_cnt_clear_wins", ic.sel_err_cnt, 0);
    tick();
    ic.in_valid = 1'b1;
    @(negedge clk);
    if (ic.in_ready) qc.push_back(32'hDEADBEEF);
    tick();
    ic.in_valid = 1'b0;
    @(negedge clk);
    chk("c_cnt_after_clear", ic.sel_err_cnt, 1);
    for (int w = 0; w < 20 && qc.size() != 0; w++) tick();
`endif

    tick();
    chk("a_queue_empty", 32'(qa.size()), 0);
    chk("b_queue_empty", 32'(qb.size()), 0);
    chk("c_queue_empty", 32'(qc.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
